brq_load_store_unit: RTL and testbench

- Load/store unit between the ID/EX stage and the data memory interface (request/grant/rvalid bus).
- Accepts one load/store at a time from ID/EX.
- Splits misaligned accesses into two word-aligned bus transactions.
- Aligns, merges and sign/zero-extends load data.
- Produces the load write-back data, the response-valid strobe and the error strobe consumed by the writeback stage.

---
 rtl/brq_load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_brq_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brq_load_store_unit.sv
// Load/store unit: one access at a time from ID/EX onto a req/gnt/rvalid data bus,
// splitting misaligned accesses into two word-aligned phases and merging load data.
module brq_load_store_unit (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_req_i,
    output logic        lsu_req_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_req_done_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,

    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rdata_valid_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic [31:0] addr_last_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        RESP1,
        REQ2,
        RESP2
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_type;
    logic        r_we;
    logic        r_sign;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_q;
    logic        r_err_q;
    logic [31:0] r_addr_last;

    logic [1:0]  w_off;
    logic [4:0]  w_shamt;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_is_word;
    logic        w_misaligned;
    logic [31:0] w_addr_base;
    logic [31:0] w_addr_next;
    logic [3:0]  w_be1;
    logic [3:0]  w_be2;
    logic [63:0] w_wdata_dbl;
    logic [63:0] w_merge_dbl;
    logic [31:0] w_raw;
    logic [31:0] w_ext;
    logic        w_in_req1;
    logic        w_in_req2;
    logic        w_final;
    logic        w_err;

    assign w_off        = r_addr[1:0];
    assign w_shamt      = {w_off, 3'b000};
    assign w_is_half    = (r_type == 2'b01);
    assign w_is_byte    = (r_type == 2'b10);
    assign w_is_word    = ~w_is_half & ~w_is_byte;
    assign w_misaligned = (w_is_word & (w_off != 2'b00)) | (w_is_half & (w_off == 2'b11));
    assign w_addr_base  = {r_addr[31:2], 2'b00};
    assign w_addr_next  = w_addr_base + 32'd4;

    assign w_in_req1    = (r_state == REQ1);
    assign w_in_req2    = (r_state == REQ2);

    always_comb begin
        w_be1 = 4'b1111 << w_off;
        if (w_is_half) begin
            w_be1 = 4'b0011 << w_off;
        end else if (w_is_byte) begin
            w_be1 = 4'b0001 << w_off;
        end
    end

    // Second phase only exists for misaligned word/half, so w_off is never 0 here.
    assign w_be2 = w_is_half ? 4'b0001 : (4'b1111 >> (3'd4 - {1'b0, w_off}));

    // Rotate store data left by the byte offset; both phases share the same lanes.
    assign w_wdata_dbl = {r_wdata, r_wdata} << w_shamt;

    assign busy_o          = (r_state != IDLE);
    assign lsu_req_ready_o = (r_state == IDLE);
    assign data_req_o      = w_in_req1 | w_in_req2;
    assign data_we_o       = data_req_o & r_we;
    assign data_wdata_o    = data_req_o ? w_wdata_dbl[63:32] : '0;

    always_comb begin
        data_addr_o = '0;
        data_be_o   = '0;
        if (w_in_req1) begin
            data_addr_o = w_addr_base;
            data_be_o   = w_be1;
        end else if (w_in_req2) begin
            data_addr_o = w_addr_next;
            data_be_o   = w_be2;
        end
    end

    assign lsu_req_done_o = data_gnt_i & ((w_in_req1 & ~w_misaligned) | w_in_req2);

    // Misaligned loads: phase-1 word is the low half of a 64-bit window.
    assign w_merge_dbl = {data_rdata_i, r_rdata_q} >> w_shamt;
    assign w_raw       = w_misaligned ? w_merge_dbl[31:0] : (data_rdata_i >> w_shamt);

    always_comb begin
        w_ext = w_raw;
        if (w_is_half) begin
            w_ext = {{16{r_sign & w_raw[15]}}, w_raw[15:0]};
        end else if (w_is_byte) begin
            w_ext = {{24{r_sign & w_raw[7]}}, w_raw[7:0]};
        end
    end

    assign w_final = data_rvalid_i &
                     (((r_state == RESP1) & ~w_misaligned) | (r_state == RESP2));
    assign w_err   = r_err_q | data_err_i;

    assign lsu_resp_valid_o  = w_final;
    assign lsu_resp_err_o    = w_final & w_err;
    assign lsu_rdata_valid_o = w_final & ~r_we & ~w_err;
    assign load_err_o        = w_final & w_err & ~r_we;
    assign store_err_o       = w_final & w_err & r_we;
    assign lsu_rdata_o       = lsu_rdata_valid_o ? w_ext : '0;
    assign addr_last_o       = r_addr_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_type      <= '0;
            r_we        <= 1'b0;
            r_sign      <= 1'b0;
            r_wdata     <= '0;
            r_rdata_q   <= '0;
            r_err_q     <= 1'b0;
            r_addr_last <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (lsu_req_i) begin
                        r_addr      <= lsu_addr_i;
                        r_type      <= lsu_type_i;
                        r_we        <= lsu_we_i;
                        r_sign      <= lsu_sign_ext_i;
                        r_wdata     <= lsu_wdata_i;
                        r_addr_last <= lsu_addr_i;
                        r_err_q     <= 1'b0;
                        r_state     <= REQ1;
                    end
                end
                REQ1: begin
                    if (data_gnt_i) begin
                        r_state <= RESP1;
                    end
                end
                RESP1: begin
                    if (data_rvalid_i) begin
                        if (w_misaligned) begin
                            r_rdata_q <= data_rdata_i;
                            r_err_q   <= data_err_i;
                            r_state   <= REQ2;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                REQ2: begin
                    if (data_gnt_i) begin
                        // A phase-1 fault keeps the original address for mtval.
                        if (!r_err_q) begin
                            r_addr_last <= w_addr_next;
                        end
                        r_state <= RESP2;
                    end
                end
                RESP2: begin
                    if (data_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brq_load_store_unit.sv
// Bench for brq_load_store_unit: vector table driven through a simple bus responder,
// responses scored against a queue of expected results.
module tb_brq_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        lsu_req_i;
    logic        lsu_req_ready_o;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_req_done_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rdata_valid_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;
    logic        load_err_o;
    logic        store_err_o;
    logic [31:0] addr_last_o;
    logic        busy_o;

    brq_load_store_unit dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .lsu_req_i         (lsu_req_i),
        .lsu_req_ready_o   (lsu_req_ready_o),
        .lsu_we_i          (lsu_we_i),
        .lsu_type_i        (lsu_type_i),
        .lsu_sign_ext_i    (lsu_sign_ext_i),
        .lsu_addr_i        (lsu_addr_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .lsu_req_done_o    (lsu_req_done_o),
        .data_req_o        (data_req_o),
        .data_gnt_i        (data_gnt_i),
        .data_addr_o       (data_addr_o),
        .data_we_o         (data_we_o),
        .data_be_o         (data_be_o),
        .data_wdata_o      (data_wdata_o),
        .data_rvalid_i     (data_rvalid_i),
        .data_err_i        (data_err_i),
        .data_rdata_i      (data_rdata_i),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_rdata_valid_o (lsu_rdata_valid_o),
        .lsu_resp_valid_o  (lsu_resp_valid_o),
        .lsu_resp_err_o    (lsu_resp_err_o),
        .load_err_o        (load_err_o),
        .store_err_o       (store_err_o),
        .addr_last_o       (addr_last_o),
        .busy_o            (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        e1;
        logic        e2;
        int unsigned wt;
        logic        two;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_last;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        rv;
        logic        err;
        logic        lerr;
        logic        serr;
        logic [31:0] last;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    exp_t mon_e;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Response monitor: every final response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && lsu_resp_valid_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", lsu_rdata_o, mon_e.rdata);
                chk("rdata_valid", {31'd0, lsu_rdata_valid_o}, {31'd0, mon_e.rv});
                chk("resp_err", {31'd0, lsu_resp_err_o}, {31'd0, mon_e.err});
                chk("load_err", {31'd0, load_err_o}, {31'd0, mon_e.lerr});
                chk("store_err", {31'd0, store_err_o}, {31'd0, mon_e.serr});
                chk("addr_last", addr_last_o, mon_e.last);
            end
        end
    end

    // Starts and ends just after a rising edge.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int unsigned nph;
        lsu_req_i      = 1'b1;
        lsu_we_i       = v.we;
        lsu_type_i     = v.typ;
        lsu_sign_ext_i = v.sx;
        lsu_addr_i     = v.addr;
        lsu_wdata_i    = v.wdata;
        @(negedge clk);
        chk("req_ready", {31'd0, lsu_req_ready_o}, 32'd1);
        @(posedge clk); #1;
        lsu_req_i = 1'b0;
        e.err   = v.we ? v.e1 : (v.e1 | (v.two & v.e2));
        e.err   = v.e1 | (v.two & v.e2);
        e.rv    = ~v.we & ~e.err;
        e.lerr  = e.err & ~v.we;
        e.serr  = e.err & v.we;
        e.rdata = e.rv ? v.exp_rdata : 32'd0;
        e.last  = v.exp_last;
        sb.push_back(e);
        nph = v.two ? 2 : 1;
        for (int unsigned p = 0; p < nph; p++) begin
            for (int unsigned w = 0; w <= v.wt; w++) begin
                data_gnt_i = (w == v.wt);
                @(negedge clk);
                chk("data_req", {31'd0, data_req_o}, 32'd1);
                chk("data_addr", data_addr_o, (p == 0) ? v.a1 : v.a2);
                chk("data_be", {28'd0, data_be_o}, {28'd0, (p == 0) ? v.be1 : v.be2});
                chk("data_we", {31'd0, data_we_o}, {31'd0, v.we});
                chk("data_wdata", data_wdata_o, v.wd);
                chk("req_done", {31'd0, lsu_req_done_o},
                    {31'd0, (w == v.wt) && (p == nph - 1)});
                @(posedge clk); #1;
            end
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b1;
            data_rdata_i  = (p == 0) ? v.rd1 : v.rd2;
            data_err_i    = (p == 0) ? v.e1 : v.e2;
            @(negedge clk);
            if (p + 1 < nph) begin
                chk("phase1_no_resp", {31'd0, lsu_resp_valid_o}, 32'd0);
            end
            @(posedge clk); #1;
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_rdata_i  = 32'h5A5A_5A5A;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we typ   sx addr          wdata          rd1            rd2            e1 e2 wt two a1         be1   a2         be2   wd             exp_rdata      err last
        vecs[0]  = '{0, 2'b00, 0, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 32'h0,         0, 0, 2, 0, 32'h100, 4'hF, 32'h0,   4'h0, 32'h0,         32'hDEADBEEF, 0, 32'h100};
        vecs[1]  = '{0, 2'b10, 1, 32'h0000_0203, 32'h0,         32'h80123456, 32'h0,         0, 0, 0, 0, 32'h200, 4'h8, 32'h0,   4'h0, 32'h0,         32'hFFFFFF80, 0, 32'h203};
        vecs[2]  = '{0, 2'b10, 0, 32'h0000_0203, 32'h0,         32'h80123456, 32'h0,         0, 0, 0, 0, 32'h200, 4'h8, 32'h0,   4'h0, 32'h0,         32'h00000080, 0, 32'h203};
        vecs[3]  = '{1, 2'b00, 0, 32'h0000_0302, 32'h11223344, 32'h0,         32'h0,         0, 0, 1, 1, 32'h300, 4'hC, 32'h304, 4'h3, 32'h33441122, 32'h0,        0, 32'h304};
        vecs[4]  = '{0, 2'b01, 1, 32'h0000_0403, 32'h0,         32'hAB000000, 32'h000000CD, 0, 0, 0, 1, 32'h400, 4'h8, 32'h404, 4'h1, 32'h0,         32'hFFFFCDAB, 0, 32'h404};
        vecs[5]  = '{0, 2'b00, 0, 32'h0000_0502, 32'h0,         32'h12345678, 32'h9ABCDEF0, 1, 0, 1, 1, 32'h500, 4'hC, 32'h504, 4'h3, 32'h0,         32'h0,        1, 32'h502};
        vecs[6]  = '{0, 2'b00, 0, 32'h0000_0502, 32'h0,         32'h12345678, 32'h9ABCDEF0, 0, 1, 0, 1, 32'h500, 4'hC, 32'h504, 4'h3, 32'h0,         32'h0,        1, 32'h504};
        vecs[7]  = '{0, 2'b01, 0, 32'h0000_0002, 32'h0,         32'h80011234, 32'h0,         0, 0, 0, 0, 32'h000, 4'hC, 32'h0,   4'h0, 32'h0,         32'h00008001, 0, 32'h002};
        vecs[8]  = '{0, 2'b01, 1, 32'h0000_0001, 32'h0,         32'h12803456, 32'h0,         0, 0, 0, 0, 32'h000, 4'h6, 32'h0,   4'h0, 32'h0,         32'hFFFF8034, 0, 32'h001};
        vecs[9]  = '{1, 2'b10, 0, 32'h0000_0601, 32'h000000A5, 32'h0,         32'h0,         0, 0, 0, 0, 32'h600, 4'h2, 32'h0,   4'h0, 32'h0000A500, 32'h0,        0, 32'h601};
        vecs[10] = '{1, 2'b00, 0, 32'h0000_0700, 32'hCAFEF00D, 32'h0,         32'h0,         1, 0, 3, 0, 32'h700, 4'hF, 32'h0,   4'h0, 32'hCAFEF00D, 32'h0,        1, 32'h700};
        vecs[11] = '{0, 2'b00, 0, 32'h0000_0501, 32'h0,         32'h44332211, 32'h88776655, 0, 0, 0, 1, 32'h500, 4'hE, 32'h504, 4'h1, 32'h0,         32'h55443322, 0, 32'h504};
        vecs[12] = '{0, 2'b11, 0, 32'h0000_0803, 32'h0,         32'hAA000000, 32'h00BBCCDD, 0, 0, 0, 1, 32'h800, 4'h8, 32'h804, 4'h7, 32'h0,         32'hBBCCDDAA, 0, 32'h804};

        rst_n          = 1'b0;
        lsu_req_i      = 1'b0;
        lsu_we_i       = 1'b0;
        lsu_type_i     = 2'b00;
        lsu_sign_ext_i = 1'b0;
        lsu_addr_i     = '0;
        lsu_wdata_i    = '0;
        data_gnt_i     = 1'b0;
        data_rvalid_i  = 1'b0;
        data_err_i     = 1'b0;
        data_rdata_i   = '0;

        @(negedge clk);
        chk("rst_ready", {31'd0, lsu_req_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_data_req", {31'd0, data_req_o}, 32'd0);
        chk("rst_be", {28'd0, data_be_o}, 32'd0);
        chk("rst_addr_last", addr_last_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // Stray grant/rvalid while idle must not start or finish anything.
        data_gnt_i    = 1'b1;
        data_rvalid_i = 1'b1;
        data_err_i    = 1'b1;
        @(negedge clk);
        chk("idle_done", {31'd0, lsu_req_done_o}, 32'd0);
        chk("idle_resp", {31'd0, lsu_resp_valid_o}, 32'd0);
        @(posedge clk); #1;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;

        // Reset asserted while the second phase of a misaligned load is requesting.
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_type_i = 2'b00;
        lsu_addr_i = 32'h0000_0902;
        @(posedge clk); #1;
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b1;
        @(posedge clk); #1;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        data_rvalid_i = 1'b0;
        @(negedge clk);
        chk("req2_data_req", {31'd0, data_req_o}, 32'd1);
        chk("req2_addr", data_addr_o, 32'h904);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data_req", {31'd0, data_req_o}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mid_ready", {31'd0, lsu_req_ready_o}, 32'd1);
        chk("rst_mid_addr_last", addr_last_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0]);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
